deinterleaver: RTL and testbench

Receive-side 802.11a PLCP DATA deinterleaver: undoes both transmit interleaver permutations over one OFDM symbol of N_CBPS coded bits. It takes the serial demapped bit stream and emits the same bits in original encoder order for the Viterbi decoder. Ping-pong buffering lets one symbol be written while the previous one is read out.

---
 rtl/deinterleaver.sv | 128 ++++++++++++
 tb/tb_deinterleaver.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/deinterleaver.sv
`default_nettype none
// ============================================================================
// Module   : deinterleaver
// Brief    : 802.11a receive deinterleaver, ping-pong banks, serial in/out.
// Revision : 1.0
// ============================================================================
module deinterleaver #(
    parameter int N_CBPS = 48,
    parameter int N_BPSC = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic In_Valid,
    input  logic Input,
    output logic Out_Valid,
    output logic Output,
    output logic Out_Start
);

    localparam int c_S  = (N_BPSC / 2 > 1) ? N_BPSC / 2 : 1;
    localparam int c_AW = $clog2(N_CBPS);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(N_CBPS - 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_READ = 1'b1;

    function automatic int f_waddr(input int j);
        int i;
        i = c_S * (j / c_S) + (j + (16 * j) / N_CBPS) % c_S;
        return 16 * i - (N_CBPS - 1) * ((16 * i) / N_CBPS);
    endfunction

    logic [c_AW-1:0]   w_rom [N_CBPS];
    logic [N_CBPS-1:0] r_mem [2];
    logic [c_AW-1:0]   r_wcnt;
    logic              r_wbank;
    logic [c_AW-1:0]   r_raddr;
    logic              r_rbank;
    logic [0:0]        r_state;
    logic [0:0]        w_next_state;
    logic              w_rd_en;
    logic              w_handoff;
    logic              r_out_valid;
    logic              r_out_bit;
    logic              r_out_start;

    // Write-address permutation is fully resolved at elaboration.
    generate
        for (genvar g = 0; g < N_CBPS; g++) begin : g_rom
            localparam int c_K = f_waddr(g);
            assign w_rom[g] = c_AW'(c_K);
        end
    endgenerate

    assign w_handoff = In_Valid && (r_wcnt == c_LAST);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_wcnt  <= '0;
            r_wbank <= 1'b0;
        end else if (In_Valid) begin
            if (w_handoff) begin
                r_wcnt  <= '0;
                r_wbank <= ~r_wbank;
            end else begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (In_Valid) begin
            r_mem[r_wbank][w_rom[r_wcnt]] <= Input;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: if (w_handoff) w_next_state = c_READ;
            c_READ: if ((r_raddr == c_LAST) && !w_handoff) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_rd_en = (r_state == c_READ);
    end

    // A handoff always restarts the reader on the bank just completed.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_raddr <= '0;
            r_rbank <= 1'b0;
        end else if (w_handoff) begin
            r_raddr <= '0;
            r_rbank <= r_wbank;
        end else if (w_rd_en) begin
            r_raddr <= (r_raddr == c_LAST) ? '0 : r_raddr + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_start <= 1'b0;
        end else begin
            r_out_valid <= w_rd_en;
            r_out_bit   <= w_rd_en ? r_mem[r_rbank][r_raddr] : 1'b0;
            r_out_start <= w_rd_en && (r_raddr == '0);
        end
    end

    assign Out_Valid = r_out_valid;
    assign Output    = r_out_bit;
    assign Out_Start = r_out_start;

endmodule
`default_nettype wire

// File: tb/tb_deinterleaver.sv
`default_nettype none
// Bench for deinterleaver: four configurations, directed table, loopback against
// a transmit-interleaver model, gapped input and asynchronous reset sequences.
module tb_deinterleaver;

    function automatic int ncbps(input int g);
        case (g)
            0: return 48;
            1: return 96;
            2: return 192;
            default: return 288;
        endcase
    endfunction

    function automatic int nbpsc(input int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 4;
            default: return 6;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst_n;
    logic iv [4];
    logic ib [4];
    logic ov [4];
    logic ob [4];
    logic os [4];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            deinterleaver #(.N_CBPS(ncbps(g)), .N_BPSC(nbpsc(g))) u_dut (
                .Clock    (clk),
                .Reset    (rst_n),
                .In_Valid (iv[g]),
                .Input    (ib[g]),
                .Out_Valid(ov[g]),
                .Output   (ob[g]),
                .Out_Start(os[g])
            );
        end
    endgenerate

    typedef struct {
        int d;
        int jpos;
        int khot;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cur   = 0;
    bit tx_q[$];
    bit exp_q[$];
    bit cap_q[$];
    int capc_q[$];
    int start_q[$];
    int e_q[$];

    always @(negedge clk) begin
        if (ov[cur]) begin
            cap_q.push_back(ob[cur]);
            capc_q.push_back(cyc);
        end
        if (os[cur]) start_q.push_back(cyc);
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic clear_cap();
        cap_q.delete();
        capc_q.delete();
        start_q.delete();
    endtask

    // Drive tx_q into DUT d; duty is the percent chance a cycle carries a bit.
    task automatic send(input int d, input int duty);
        int n;
        n = ncbps(d);
        e_q.delete();
        for (int x = 0; x < tx_q.size(); x++) begin
            while (duty < 100 && $urandom_range(99) >= duty) begin
                iv[d] = 1'b0;
                @(posedge clk);
                #1;
            end
            iv[d] = 1'b1;
            ib[d] = tx_q[x];
            @(posedge clk);
            #1;
            if ((x + 1) % n == 0) e_q.push_back(cyc);
        end
        iv[d] = 1'b0;
        ib[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        repeat (ncbps(d) + 4) @(posedge clk);
        #1;
    endtask

    // Transmit interleaver applied to random source bits: exp_q = source, tx_q = air order.
    task automatic build_tx(input int d, input int nsym);
        int n, s, i, j;
        bit tmp[288];
        n = ncbps(d);
        s = (nbpsc(d) / 2 > 1) ? nbpsc(d) / 2 : 1;
        exp_q.delete();
        tx_q.delete();
        for (int b = 0; b < nsym * n; b++) exp_q.push_back(bit'($urandom_range(1)));
        for (int sym = 0; sym < nsym; sym++) begin
            for (int k = 0; k < n; k++) begin
                i = (n / 16) * (k % 16) + k / 16;
                j = s * (i / s) + (i + n - (16 * i) / n) % s;
                tmp[j] = exp_q[sym * n + k];
            end
            for (int x = 0; x < n; x++) tx_q.push_back(tmp[x]);
        end
    endtask

    task automatic verify(input string tag, input int d);
        int n, berr, terr, serr, ns;
        n = ncbps(d);
        ns = e_q.size();
        berr = 0;
        terr = 0;
        serr = 0;
        check({tag, " count"}, cap_q.size(), exp_q.size());
        for (int k = 0; k < cap_q.size() && k < exp_q.size(); k++) begin
            if (cap_q[k] != exp_q[k]) berr++;
            if (k / n >= ns || capc_q[k] != e_q[k / n] + 1 + k % n) terr++;
        end
        check({tag, " bit errors"}, berr, 0);
        check({tag, " timing errors"}, terr, 0);
        check({tag, " start count"}, start_q.size(), ns);
        for (int s = 0; s < ns; s++)
            if (s >= start_q.size() || start_q[s] != e_q[s] + 1) serr++;
        check({tag, " start timing errors"}, serr, 0);
        check({tag, " idle valid"}, int'(ov[d]), 0);
    endtask

    initial begin
        vec_t tbl [8];
        tbl[0] = '{d: 0, jpos: 1,  khot: 16};
        tbl[1] = '{d: 0, jpos: 3,  khot: 1};
        tbl[2] = '{d: 0, jpos: 47, khot: 47};
        tbl[3] = '{d: 0, jpos: 0,  khot: 0};
        tbl[4] = '{d: 2, jpos: 12, khot: 17};
        tbl[5] = '{d: 2, jpos: 1,  khot: 16};
        tbl[6] = '{d: 1, jpos: 6,  khot: 1};
        tbl[7] = '{d: 3, jpos: 18, khot: 17};

        rst_n = 1'b0;
        for (int g = 0; g < 4; g++) begin
            iv[g] = 1'b0;
            ib[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++)
            check($sformatf("reset outputs dut%0d", g), int'({ov[g], ob[g], os[g]}), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int t = 0; t < 8; t++) begin
            int n;
            n = ncbps(tbl[t].d);
            cur = tbl[t].d;
            tx_q.delete();
            exp_q.delete();
            for (int x = 0; x < n; x++) begin
                tx_q.push_back(x == tbl[t].jpos);
                exp_q.push_back(x == tbl[t].khot);
            end
            clear_cap();
            send(tbl[t].d, 100);
            drain(tbl[t].d);
            verify($sformatf("table%0d", t), tbl[t].d);
        end

        for (int d = 0; d < 4; d++) begin
            cur = d;
            build_tx(d, 3);
            clear_cap();
            send(d, 100);
            drain(d);
            verify($sformatf("loopback n%0d", ncbps(d)), d);
        end

        cur = 1;
        build_tx(1, 2);
        clear_cap();
        send(1, 30);
        drain(1);
        verify("gapped n96", 1);

        cur = 0;
        tx_q.delete();
        for (int x = 0; x < 20; x++) tx_q.push_back(1'b1);
        clear_cap();
        send(0, 100);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        build_tx(0, 1);
        clear_cap();
        send(0, 100);
        drain(0);
        verify("after partial reset", 0);

        build_tx(0, 1);
        clear_cap();
        send(0, 100);
        repeat (10) @(posedge clk);
        #2;
        check("valid before mid-read reset", int'(ov[0]), 1);
        rst_n = 1'b0;
        #1;
        check("outputs during mid-read reset", int'({ov[0], ob[0], os[0]}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_cap();
        repeat (60) @(posedge clk);
        #1;
        check("stale output after reset", cap_q.size(), 0);
        build_tx(0, 1);
        clear_cap();
        send(0, 100);
        drain(0);
        verify("after mid-read reset", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
